// File: rtl/pipeline_stall_ctrl_if.sv
// Bus between the core's stage registers (master) and the pipeline stall controller (slave).
interface pipeline_stall_ctrl_if;
  logic        dec_valid;
  logic [3:0]  dec_src1;
  logic [3:0]  dec_src2;
  logic        ex_valid;
  logic [3:0]  ex_dst;
  logic        ex_flag_wr;
  logic        wb_valid;
  logic [3:0]  wb_dst;
  logic        mem_req;
  logic        mem_ack;
  logic        jump_taken;
  logic        irq_req;
  logic [7:0]  irq_num;
  logic        stall_fetch;
  logic        stall_decode;
  logic        stall_exec;
  logic        flush_decode;
  logic        irq_ack;
  logic        inj_irq;
  logic [7:0]  inj_irq_num;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output dec_valid, dec_src1, dec_src2, ex_valid, ex_dst, ex_flag_wr,
           wb_valid, wb_dst, mem_req, mem_ack, jump_taken, irq_req, irq_num,
    input  stall_fetch, stall_decode, stall_exec, flush_decode,
           irq_ack, inj_irq, inj_irq_num, mem_timeout, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_src1, dec_src2, ex_valid, ex_dst, ex_flag_wr,
           wb_valid, wb_dst, mem_req, mem_ack, jump_taken, irq_req, irq_num,
    output stall_fetch, stall_decode, stall_exec, flush_decode,
           irq_ack, inj_irq, inj_irq_num, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Fetch/decode/execute stall, flush and soft-interrupt sequencer.
// Optional macro STALL_PERF_CNT_EN builds the saturating stall_cycles counter.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipeline_stall_ctrl_if.slave        bus,
  output logic [2:0]                  o_dbg_state
);
  // Handshakes: mem_req is held until mem_ack (or timeout abort); irq_req is a
  // level held until irq_ack; jump_taken is a single-cycle pulse.
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_HAZ   = 3'd1,
    ST_MEMW  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_IRQ   = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LAST  = 16'(MEM_TIMEOUT - 1);
  localparam logic [2:0]  FL_RELOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [2:0]  FL_FULL   = 3'(FLUSH_DEPTH);
  localparam bit          FL_MULTI  = (FLUSH_DEPTH > 1);

  state_t      r_state;
  logic [15:0] r_mem_cnt;
  logic [2:0]  r_flush_cnt;
  logic        r_haz_dwell;
  logic        r_jump_pend;
  logic        r_irq_ack;
  logic        r_inj_irq;
  logic [7:0]  r_inj_num;
  logic        r_mem_timeout;

  logic w_haz1, w_haz2, w_haz, w_live, w_mem_start, w_tmo_hit, w_mem_done;
  logic w_stall_fe, w_stall_de, w_stall_ex, w_flush;

  assign w_haz1 = (bus.dec_src1 != 4'd0) &&
                  ((bus.ex_valid && (bus.dec_src1 == bus.ex_dst)) ||
                   (bus.wb_valid && (bus.dec_src1 == bus.wb_dst)) ||
                   ((bus.dec_src1 == 4'd9) && bus.ex_flag_wr));
  assign w_haz2 = (bus.dec_src2 != 4'd0) &&
                  ((bus.ex_valid && (bus.dec_src2 == bus.ex_dst)) ||
                   (bus.wb_valid && (bus.dec_src2 == bus.wb_dst)) ||
                   ((bus.dec_src2 == 4'd9) && bus.ex_flag_wr));
  assign w_haz       = bus.dec_valid && (w_haz1 || w_haz2);
  assign w_live      = (r_state == ST_RUN) || (r_state == ST_HAZ) || (r_state == ST_IRQ);
  assign w_mem_start = bus.mem_req && !bus.mem_ack;
  assign w_tmo_hit   = (r_mem_cnt == TMO_LAST);
  assign w_mem_done  = bus.mem_ack || w_tmo_hit;

  // Mealy stop/flush: a jump discards the stale decode slot instead of stalling it.
  always_comb begin
    w_stall_fe = 1'b0;
    w_stall_de = 1'b0;
    w_stall_ex = 1'b0;
    w_flush    = 1'b0;
    if (rst_n) begin
      if (w_live) begin
        if (bus.jump_taken) begin
          w_flush = 1'b1;
        end else if (w_mem_start) begin
          w_stall_fe = 1'b1;
          w_stall_de = 1'b1;
          w_stall_ex = 1'b1;
        end else if (w_haz) begin
          w_stall_fe = 1'b1;
          w_stall_de = 1'b1;
          w_flush    = 1'b1;
        end
      end else if (r_state == ST_MEMW) begin
        w_stall_fe = !w_mem_done;
        w_stall_de = !w_mem_done;
        w_stall_ex = !w_mem_done;
      end else if (r_state == ST_FLUSH) begin
        w_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_mem_cnt     <= 16'd0;
      r_flush_cnt   <= 3'd0;
      r_haz_dwell   <= 1'b0;
      r_jump_pend   <= 1'b0;
      r_irq_ack     <= 1'b0;
      r_inj_irq     <= 1'b0;
      r_inj_num     <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_irq_ack <= 1'b0;
      r_inj_irq <= 1'b0;
      r_inj_num <= 8'd0;
      case (r_state)
        ST_RUN, ST_HAZ, ST_IRQ: begin
          r_haz_dwell <= 1'b0;
          if (bus.jump_taken) begin
            r_flush_cnt <= FL_RELOAD;
            r_state     <= FL_MULTI ? ST_FLUSH : ST_RUN;
          end else if (w_mem_start) begin
            r_mem_cnt <= 16'd0;
            r_state   <= ST_MEMW;
          end else if (w_haz) begin
            if ((r_state == ST_HAZ) && r_haz_dwell) begin
              r_state <= ST_RUN;
            end else begin
              r_state     <= ST_HAZ;
              r_haz_dwell <= (r_state == ST_HAZ);
            end
          end else if (bus.irq_req && (r_state == ST_RUN)) begin
            r_irq_ack <= 1'b1;
            r_inj_irq <= 1'b1;
            r_inj_num <= bus.irq_num;
            r_state   <= ST_IRQ;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_MEMW: begin
          if (w_mem_done) begin
            if (w_tmo_hit && !bus.mem_ack) r_mem_timeout <= 1'b1;
            r_jump_pend <= 1'b0;
            // A jump resolved while waiting gets a full flush once memory is released.
            if (r_jump_pend || bus.jump_taken) begin
              r_flush_cnt <= FL_FULL;
              r_state     <= ST_FLUSH;
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            r_mem_cnt <= r_mem_cnt + 16'd1;
            if (bus.jump_taken) r_jump_pend <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (bus.jump_taken) begin
            r_flush_cnt <= FL_RELOAD;
            if (!FL_MULTI) r_state <= ST_RUN;
          end else if (r_flush_cnt <= 3'd1) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.stall_fetch  = w_stall_fe;
  assign bus.stall_decode = w_stall_de;
  assign bus.stall_exec   = w_stall_ex;
  assign bus.flush_decode = w_flush;
  assign bus.irq_ack      = r_irq_ack;
  assign bus.inj_irq      = r_inj_irq;
  assign bus.inj_irq_num  = r_inj_num;
  assign bus.mem_timeout  = r_mem_timeout;
  assign o_dbg_state      = r_state;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall_de && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (MEM_TIMEOUT=8, FLUSH_DEPTH=2).
module tb_pipeline_stall_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  pipeline_stall_ctrl_if bus();

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT(8),
    .FLUSH_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          exp_perf = 0;
  logic        exp_tmo  = 1'b0;
  logic [14:0] exp_q[$];
  logic [14:0] got;
  logic [14:0] want;

  // Packed view: {sf, sd, se, fd, ack, inj, num[7:0], tmo}; sd is bit 13.
  function automatic logic [14:0] ev(input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic ack, input logic inj,
                                     input logic [7:0] num);
    return {sf, sd, se, fd, ack, inj, num, exp_tmo};
  endfunction

  function automatic logic [14:0] pack();
    return {bus.stall_fetch, bus.stall_decode, bus.stall_exec, bus.flush_decode,
            bus.irq_ack, bus.inj_irq, bus.inj_irq_num, bus.mem_timeout};
  endfunction

  function automatic logic src_hz(input logic [3:0] s);
    return (s != 4'd0) && ((bus.ex_valid && (s == bus.ex_dst)) ||
                           (bus.wb_valid && (s == bus.wb_dst)) ||
                           ((s == 4'd9) && bus.ex_flag_wr));
  endfunction

  task automatic set_idle();
    bus.dec_valid = 1'b0; bus.dec_src1 = 4'd0; bus.dec_src2 = 4'd0;
    bus.ex_valid = 1'b0; bus.ex_dst = 4'd0; bus.ex_flag_wr = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_dst = 4'd0;
    bus.mem_req = 1'b0; bus.mem_ack = 1'b0; bus.jump_taken = 1'b0;
    bus.irq_req = 1'b0; bus.irq_num = 8'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_tmo = 1'b0;
    exp_perf = 0;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
    @(negedge clk);
    got = pack(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_err++; $display("FAIL reset_outputs: got=%h expected=%h", got, want); end
    n_checks++;
    if (bus.stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_perf: got=%0d expected=0", bus.stall_cycles); end
    n_checks++;
    if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got=%0d expected=0", dbg_state); end
    tick();
  endtask

  task automatic test_hazard();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      case (c)
        0: begin bus.dec_valid = 1; bus.dec_src1 = 4'd3; bus.ex_valid = 1; bus.ex_dst = 4'd3;
                 exp_q.push_back(ev(1, 1, 0, 1, 0, 0, 8'h00)); end
        2: begin bus.dec_valid = 1; bus.dec_src1 = 4'd0; bus.ex_valid = 1; bus.ex_dst = 4'd0;
                 exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00)); end
        3: begin bus.dec_valid = 1; bus.dec_src2 = 4'd5; bus.wb_valid = 1; bus.wb_dst = 4'd5;
                 exp_q.push_back(ev(1, 1, 0, 1, 0, 0, 8'h00)); end
        4: begin bus.dec_src1 = 4'd5; bus.wb_valid = 1; bus.wb_dst = 4'd5;
                 exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00)); end
        default: exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
      endcase
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL hazard c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
  endtask

  task automatic test_flag_hazard();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      if (c < 2) begin
        bus.dec_valid = 1; bus.dec_src2 = 4'd9; bus.ex_valid = 1; bus.ex_dst = 4'd2;
        bus.ex_flag_wr = (c == 0);
      end
      exp_q.push_back(c == 0 ? ev(1, 1, 0, 1, 0, 0, 8'h00) : ev(0, 0, 0, 0, 0, 0, 8'h00));
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL flag_hazard c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
  endtask

  task automatic test_memory();
    for (int c = 0; c < 9; c++) begin
      set_idle();
      if (c <= 5) bus.mem_req = 1;
      if (c == 5) bus.mem_ack = 1;
      if (c == 7) begin bus.mem_req = 1; bus.mem_ack = 1; end
      if (c < 5) exp_q.push_back(ev(1, 1, 1, 0, 0, 0, 8'h00));
      else       exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL memory c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
  endtask

  task automatic test_jump();
    for (int c = 0; c < 7; c++) begin
      set_idle();
      if (c == 0 || c == 3 || c == 4) bus.jump_taken = 1;
      if (c == 3 || c == 5) begin
        bus.dec_valid = 1; bus.dec_src1 = 4'd4; bus.ex_valid = 1; bus.ex_dst = 4'd4;
      end
      if (c == 2 || c == 6) exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
      else                  exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 8'h00));
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL jump c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
  endtask

  task automatic test_jump_in_memw();
    for (int c = 0; c < 7; c++) begin
      set_idle();
      if (c <= 3) bus.mem_req = 1;
      if (c == 1) bus.jump_taken = 1;
      if (c == 3) bus.mem_ack = 1;
      if (c < 3)                exp_q.push_back(ev(1, 1, 1, 0, 0, 0, 8'h00));
      else if (c == 4 || c == 5) exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 8'h00));
      else                      exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL jump_in_memw c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
  endtask

  task automatic test_irq();
    for (int c = 0; c < 4; c++) begin
      set_idle();
      if (c < 2) begin bus.irq_req = 1; bus.irq_num = 8'h2A; end
      if (c == 1) exp_q.push_back(ev(0, 0, 0, 0, 1, 1, 8'h2A));
      else        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL irq c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
  endtask

  task automatic test_irq_with_jump();
    for (int c = 0; c < 9; c++) begin
      set_idle();
      if (c <= 3) begin bus.irq_req = 1; bus.irq_num = 8'h55; end
      if (c == 5 || c == 6) begin bus.irq_req = 1; bus.irq_num = 8'h11; end
      if (c == 0 || c == 6) bus.jump_taken = 1;
      case (c)
        0, 1, 7: exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 8'h00));
        3:       exp_q.push_back(ev(0, 0, 0, 0, 1, 1, 8'h55));
        6:       exp_q.push_back(ev(0, 0, 0, 1, 1, 1, 8'h11));
        default: exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
      endcase
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL irq_with_jump c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
  endtask

  task automatic test_random_hazard();
    logic h;
    for (int c = 0; c < 40; c++) begin
      set_idle();
      bus.dec_valid  = 1'($urandom_range(0, 3) != 0);
      bus.dec_src1   = 4'($urandom_range(0, 10));
      bus.dec_src2   = 4'($urandom_range(0, 10));
      bus.ex_valid   = 1'($urandom_range(0, 1));
      bus.ex_dst     = 4'($urandom_range(0, 10));
      bus.ex_flag_wr = 1'($urandom_range(0, 1));
      bus.wb_valid   = 1'($urandom_range(0, 1));
      bus.wb_dst     = 4'($urandom_range(0, 10));
      h = bus.dec_valid && (src_hz(bus.dec_src1) || src_hz(bus.dec_src2));
      exp_q.push_back(ev(h, h, 0, h, 0, 0, 8'h00));
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL random_hazard c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 11; c++) begin
      set_idle();
      if (c <= 8) bus.mem_req = 1;
      if (c == 9) exp_tmo = 1'b1;
      if (c < 8) exp_q.push_back(ev(1, 1, 1, 0, 0, 0, 8'h00));
      else       exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL timeout c%0d: got=%h expected=%h", c, got, want); end
      if (want[13]) exp_perf++;
      tick();
    end
  endtask

  task automatic test_reset_in_memw();
    logic [31:0] perf_want;
    for (int c = 0; c < 2; c++) begin
      set_idle();
      bus.mem_req = 1;
      exp_q.push_back(ev(1, 1, 1, 0, 0, 0, 8'h00));
      @(negedge clk);
      got = pack(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_err++; $display("FAIL reset_memw c%0d: got=%h expected=%h", c, got, want); end
`ifdef STALL_PERF_CNT_EN
      perf_want = 32'(exp_perf);
`else
      perf_want = 32'd0;
`endif
      n_checks++;
      if (bus.stall_cycles !== perf_want) begin
        n_err++; $display("FAIL perf_count c%0d: got=%0d expected=%0d", c, bus.stall_cycles, perf_want);
      end
      if (want[13]) exp_perf++;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_idle();
    exp_tmo = 1'b0;
    exp_perf = 0;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 8'h00));
    @(negedge clk);
    got = pack(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_err++; $display("FAIL reset_memw_after: got=%h expected=%h", got, want); end
    n_checks++;
    if (bus.stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_memw_perf: got=%0d expected=0", bus.stall_cycles); end
    n_checks++;
    if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_memw_state: got=%0d expected=0", dbg_state); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_idle();
    test_reset();
    test_hazard();
    test_flag_hazard();
    test_memory();
    test_jump();
    test_jump_in_memw();
    test_irq();
    test_irq_with_jump();
    test_random_hazard();
    test_timeout();
    test_reset_in_memw();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central pipeline sequencer for the fetch / decode (operand-fetch) / execute pipe. It produces the per-stage stop signals and the decode-output bubble from three sources: register hazards between decode and the later stages, outstanding memory handshakes, and resolved jumps. It also injects soft interrupts into the decode stage's interrupt sideband. It sits beside the core's stage registers and drives their `isStop` inputs directly.

## Interface
- `MEM_TIMEOUT`, 255: max cycles to wait for `mem_ack` before abort; range 2..65535.
- `FLUSH_DEPTH`, 2: cycles of fetch/decode flush after a taken jump; range 1..7.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `dec_valid` in 1: decode stage holds a live instruction.
- `dec_src1`, `dec_src2` in 4: register channels the decoding instruction reads; 0 = none.
- `ex_valid` in 1, `ex_dst` in 4, `ex_flag_wr` in 1: execute-stage instruction, its y1 destination, and whether it writes flag (y2 = 1).
- `wb_valid` in 1, `wb_dst` in 4: writeback-stage instruction and its destination.
- `mem_req` in 1, `mem_ack` in 1: execute-stage memory access request and completion.
- `jump_taken` in 1: one-cycle pulse; execute resolved a PC change.
- `irq_req` in 1, `irq_num` in 8: level soft-interrupt request and vector; held until acked.
- `stall_fetch`, `stall_decode`, `stall_exec` out 1: stage stop signals.
- `flush_decode` out 1: decode registers load mode 0 (NOP) this cycle.
- `irq_ack` out 1: one-cycle pulse accepting `irq_req`.
- `inj_irq` out 1, `inj_irq_num` out 8: interrupt injected into the decode sideband.
- `mem_timeout` out 1: sticky error flag.
- `stall_cycles` out 32: performance counter (see Configuration).

## Operation
- States: RUN, HAZ, MEMW, FLUSH, IRQ.
- Event priority, evaluated each cycle in RUN: `jump_taken` > memory > hazard > irq.
- Hazard condition: `dec_valid` and a nonzero `dec_srcN` that equals either
  - `ex_dst` with `ex_valid`, or
  - `wb_dst` with `wb_valid`.
  - `dec_srcN`==9 with `ex_flag_wr` also counts as a hazard.
- HAZ behaviour: `stall_fetch`=`stall_decode`=1, `flush_decode`=1, execute runs. Exit to RUN on the first cycle the condition is false. Maximum dwell is 2 cycles.
- MEMW:
  - Entered when `mem_req`=1 and `mem_ack`=0. All three stalls = 1.
  - A 16-bit counter increments each cycle.
  - `mem_ack` → RUN.
  - Counter == `MEM_TIMEOUT`-1 → set `mem_timeout`, go to RUN.
  - `mem_req` with `mem_ack` in the same cycle causes no stall.
- FLUSH:
  - `jump_taken` from any state except MEMW forces FLUSH for `FLUSH_DEPTH` cycles (3-bit counter).
  - During FLUSH: `flush_decode`=1, stalls = 0, hazard checks suppressed.
  - A `jump_taken` inside FLUSH reloads the counter.
  - `jump_taken` during MEMW is latched and applied on MEMW exit.
- IRQ:
  - Entered when `irq_req`=1 in RUN with no higher event. `irq_num` is captured.
  - Next cycle: `irq_ack`=1, `inj_irq`=1, `inj_irq_num`=captured value, then back to RUN.
  - A jump arriving in IRQ still completes the injection, then goes to FLUSH.
- `mem_timeout` clears only on reset.

## Timing
- Reset (`rst_n`=0 at posedge): state RUN, all counters 0, every output 0, latched jump cleared. Reset mid-stall or mid-flush drops all stalls on the next cycle.
- `stall_*` and `flush_decode` are Mealy. They are combinational from state plus current inputs, so a hazard or `mem_req` stalls in the same cycle it appears.
- `irq_ack`, `inj_irq`, `inj_irq_num` and `mem_timeout` are registered; injection latency is 1 cycle after request acceptance.
- Stage registers sample stop/flush on the same posedge; there is no extra delay.
- Simultaneous `jump_taken` and hazard: FLUSH wins, and the stale decode instruction is discarded rather than stalled.

## Configuration
- `STALL_PERF_CNT_EN` defined:
  - `stall_cycles` counts cycles where `stall_decode`=1.
  - It is 32-bit and saturating at 0xFFFFFFFF.
  - It clears on reset.
- `STALL_PERF_CNT_EN` undefined: `stall_cycles` is tied to 0 and no counter logic is built.

## Test plan
- Hazard: `dec_src1`=3 and `ex_dst`=3 with `ex_valid`=1 for 1 cycle → `stall_fetch`=`stall_decode`=`flush_decode`=1 that cycle, then RUN. With `dec_src1`=0 → no stall.
- Flag hazard: `dec_src2`=9 with `ex_flag_wr`=1 → stall. Same case with `ex_flag_wr`=0 → none.
- Memory: `mem_req`=1, `mem_ack` after 5 cycles → all stalls high for exactly 5 cycles. With `MEM_TIMEOUT`=8 and no ack → release after 8 cycles and `mem_timeout`=1 sticky.
- Jump: `jump_taken` pulse with `FLUSH_DEPTH`=2 → `flush_decode` high for 2 cycles. A second pulse at cycle 1 → 3 cycles total. A pulse during MEMW → flush starts the cycle after ack.
- IRQ: `irq_req`=1, `irq_num`=0x2A in RUN → next cycle `irq_ack`=`inj_irq`=1 and `inj_irq_num`=0x2A for one cycle. Asserted together with `jump_taken` → flush first, ack after FLUSH ends.
- Reset: `rst_n`=0 during MEMW → all outputs 0 next cycle. With the macro, `stall_cycles` returns to 0.
